prbs7_chk: RTL and testbench

Self-synchronising PRBS7 (x^7 + x^6 + 1) checker for the receive side of one transceiver lane. It takes the 8-bit parallel word recovered on the lane RX clock and predicts the next word from the sequence history. It acquires and holds lock, and reports per-word errors and a saturating error count. Its `lock_o` and `chk_data_o` are the `prbs7_lock_lnN` and `qX_lnN_prbs7_chk_data` signals fed to the on-chip analyzer probes.

---
 rtl/prbs7_chk_if.sv | 23 ++
 rtl/prbs7_chk.sv | 111 +++++++++++
 tb/tb_prbs7_chk.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs7_chk_if.sv
// Receive-lane bundle for the PRBS7 checker: recovered word in, lock/error status out.
// The master drives the lane data; the slave side is the checker.
interface prbs7_chk_if #(
    parameter int ERR_CNT_W = 16
);
    logic [7:0]           rx_data_i;
    logic                 rx_valid_i;
    logic                 clr_i;
    logic                 lock_o;
    logic                 err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;
    logic [7:0]           chk_data_o;

    modport master (
        output rx_data_i, rx_valid_i, clr_i,
        input  lock_o, err_o, err_cnt_o, chk_data_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, clr_i,
        output lock_o, err_o, err_cnt_o, chk_data_o
    );
endinterface

// File: rtl/prbs7_chk.sv
// Self-synchronising PRBS7 (x^7 + x^6 + 1) word checker with lock tracking.
// Define PRBS7_CHK_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt_o is 0.
module prbs7_chk #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    prbs7_chk_if.slave  bus
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t     state;
    logic [6:0] hist;
    logic [7:0] good_cnt;
    logic [3:0] bad_cnt;
    logic       lock_q;
    logic       err_q;
    logic [7:0] chk_q;

    logic       e0;
    logic       e1;
    logic [7:0] exp_word;
    logic       mismatch;
    logic [7:0] good_next;
    logic [3:0] bad_next;
    logic       err_inc;

    // hist[6] is the most recent line bit; the top two bits feed back from bits of this word.
    assign e0       = hist[0] ^ hist[1];
    assign e1       = hist[1] ^ hist[2];
    assign exp_word = {e0 ^ e1, hist[6] ^ e0,
                       hist[5] ^ hist[6], hist[4] ^ hist[5], hist[3] ^ hist[4],
                       hist[2] ^ hist[3], e1, e0};

    assign mismatch  = (bus.rx_data_i != exp_word);
    assign good_next = ((hist == 7'd0) || mismatch) ? 8'd0 : good_cnt + 8'd1;
    assign bad_next  = bad_cnt + 4'd1;
    assign err_inc   = bus.rx_valid_i && (state == LOCKED) && mismatch;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= SEARCH;
            hist     <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            chk_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (bus.rx_valid_i) begin
                chk_q <= exp_word;
                case (state)
                    SEARCH: begin
                        hist     <= bus.rx_data_i[7:1];
                        good_cnt <= good_next;
                        if (good_next == 8'(LOCK_CNT)) begin
                            state   <= LOCKED;
                            lock_q  <= 1'b1;
                            bad_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        err_q <= mismatch;
                        if (mismatch && (bad_next == 4'(UNLOCK_CNT))) begin
                            // Give up on the free-running generator and reseed from the line.
                            state    <= SEARCH;
                            lock_q   <= 1'b0;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                            hist     <= bus.rx_data_i[7:1];
                        end else begin
                            bad_cnt <= mismatch ? bad_next : 4'd0;
                            hist    <= exp_word[7:1];
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef PRBS7_CHK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    // A clear coinciding with an error still records that error.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt <= '0;
        end else if (bus.clr_i) begin
            err_cnt <= ERR_CNT_W'(err_inc);
        end else if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.err_cnt_o = err_cnt;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = bus.clr_i ^ err_inc;
    assign bus.err_cnt_o     = {ERR_CNT_W{1'b0}};
`endif

    assign bus.lock_o     = lock_q;
    assign bus.err_o      = err_q;
    assign bus.chk_data_o = chk_q;

endmodule

// File: tb/tb_prbs7_chk.sv
// Randomised bench for prbs7_chk against a bit-serial PRBS7 model of the checker rules.
// Follows PRBS7_CHK_ERR_CNT_EN: with it undefined the counter is expected to stay at 0.
module tb_prbs7_chk;

    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;
    localparam int ERR_CNT_W  = 4;
    localparam int CNT_MAX    = (1 << ERR_CNT_W) - 1;
`ifdef PRBS7_CHK_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;

    prbs7_chk_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

    prbs7_chk #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model state: the last seven sequence bits, oldest first.
    bit         m_hist[$];
    bit         m_locked;
    int         m_good;
    int         m_bad;
    int         m_cnt;
    bit         m_err;
    logic [7:0] m_chk;

    // Independent stimulus generator, same polynomial, seeded 7'h7F.
    bit         g_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
        m_locked = 1'b0;
        m_good   = 0;
        m_bad    = 0;
        m_cnt    = 0;
        m_err    = 1'b0;
        m_chk    = 8'h00;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) m_hist.push_back(w[i]);
        while (m_hist.size() > 7) void'(m_hist.pop_front());
    endtask

    function automatic logic [7:0] predict();
        bit         q[$];
        logic [7:0] w;
        q = m_hist;
        for (int i = 0; i < 8; i++) begin
            bit b;
            b = q[q.size() - 7] ^ q[q.size() - 6];
            q.push_back(b);
            w[i] = b;
        end
        return w;
    endfunction

    task automatic model_step(input logic [7:0] data, input bit valid, input bit clr);
        bit         inc;
        bit         zero;
        bit         mis;
        logic [7:0] e;
        inc   = 1'b0;
        m_err = 1'b0;
        if (valid) begin
            e     = predict();
            mis   = (data != e);
            m_chk = e;
            if (!m_locked) begin
                zero = 1'b1;
                foreach (m_hist[i]) if (m_hist[i]) zero = 1'b0;
                m_good = (mis || zero) ? 0 : m_good + 1;
                push_word(data);
                if (m_good == LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_bad    = 0;
                end
            end else begin
                m_err = mis;
                inc   = mis;
                m_bad = mis ? m_bad + 1 : 0;
                if (m_bad == UNLOCK_CNT) begin
                    m_locked = 1'b0;
                    m_good   = 0;
                    m_bad    = 0;
                    push_word(data);
                end else begin
                    push_word(e);
                end
            end
        end
        if (clr) m_cnt = inc ? 1 : 0;
        else if (inc && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic gen_reset();
        g_q.delete();
        for (int i = 0; i < 7; i++) g_q.push_back(1'b1);
    endtask

    task automatic next_clean(output logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            bit b;
            b = g_q[0] ^ g_q[1];
            g_q.push_back(b);
            void'(g_q.pop_front());
            w[i] = b;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit valid, input bit clr);
        @(negedge clk_i);
        bus.rx_data_i  = data;
        bus.rx_valid_i = valid;
        bus.clr_i      = clr;
        @(posedge clk_i);
        model_step(data, valid, clr);
        #1;
        checkOutput("lock", 32'(bus.lock_o), 32'(m_locked));
        checkOutput("err", 32'(bus.err_o), 32'(m_err));
        checkOutput("err_cnt", 32'(bus.err_cnt_o), 32'(CNT_EN ? m_cnt : 0));
        checkOutput("chk_data", 32'(bus.chk_data_o), 32'(m_chk));
    endtask

    task automatic send_clean(input int n, input bit gaps);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            while (gaps && ($urandom_range(0, 1) == 1)) applyStimulus(8'($urandom), 1'b0, 1'b0);
            next_clean(w);
            applyStimulus(w, 1'b1, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_lock"}, 32'(bus.lock_o), 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.err_o), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(bus.err_cnt_o), 32'd0);
        checkOutput({tag, "_chk"}, 32'(bus.chk_data_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] w;
        int         pulses;

        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.clr_i      = 1'b0;
        model_reset();
        gen_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        $display("[TB] clean stream");
        for (int i = 1; i <= 1000; i++) begin
            next_clean(w);
            applyStimulus(w, 1'b1, 1'b0);
            if (i == LOCK_CNT) checkOutput("lock_word16", 32'(bus.lock_o), 32'd0);
            if (i == LOCK_CNT + 1) checkOutput("lock_word17", 32'(bus.lock_o), 32'd1);
        end
        checkOutput("cnt_after_1000", 32'(bus.err_cnt_o), 32'd0);

        $display("[TB] single-bit error");
        next_clean(w);
        applyStimulus(w ^ 8'h08, 1'b1, 1'b0);
        checkOutput("single_err", 32'(bus.err_o), 32'd1);
        checkOutput("single_chk", 32'(bus.chk_data_o), 32'(w));
        checkOutput("single_lock", 32'(bus.lock_o), 32'd1);
        checkOutput("single_cnt", 32'(bus.err_cnt_o), CNT_EN ? 32'd1 : 32'd0);
        send_clean(1, 1'b0);
        checkOutput("single_next_clean", 32'(bus.err_o), 32'd0);

        $display("[TB] loss of lock");
        next_clean(w);
        applyStimulus(w, 1'b1, 1'b1);
        checkOutput("clr_alone_a", 32'(bus.err_cnt_o), 32'd0);
        pulses = 0;
        for (int k = 0; k < UNLOCK_CNT; k++) begin
            next_clean(w);
            applyStimulus(w ^ 8'($urandom_range(1, 255)), 1'b1, 1'b0);
            pulses += int'(bus.err_o);
        end
        checkOutput("lol_pulses", 32'(pulses), 32'(UNLOCK_CNT));
        checkOutput("lol_lock", 32'(bus.lock_o), 32'd0);
        checkOutput("lol_cnt", 32'(bus.err_cnt_o), CNT_EN ? 32'(UNLOCK_CNT) : 32'd0);
        send_clean(LOCK_CNT + 2, 1'b0);
        checkOutput("relock", 32'(bus.lock_o), 32'd1);

        $display("[TB] idle line and valid gaps");
        for (int i = 0; i < 100; i++) applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("idle_lock", 32'(bus.lock_o), 32'd0);
        send_clean(40, 1'b0);
        checkOutput("idle_relock", 32'(bus.lock_o), 32'd1);
        send_clean(200, 1'b1);
        checkOutput("gap_lock", 32'(bus.lock_o), 32'd1);

        $display("[TB] counter saturation and clear");
        for (int k = 0; k < 20; k++) begin
            next_clean(w);
            applyStimulus(w ^ 8'(1 << $urandom_range(0, 7)), 1'b1, 1'b0);
            send_clean(1, 1'b0);
        end
        checkOutput("sat_cnt", 32'(bus.err_cnt_o), CNT_EN ? 32'(CNT_MAX) : 32'd0);
        next_clean(w);
        applyStimulus(w ^ 8'h10, 1'b1, 1'b1);
        checkOutput("clr_with_err", 32'(bus.err_cnt_o), CNT_EN ? 32'd1 : 32'd0);
        next_clean(w);
        applyStimulus(w, 1'b1, 1'b1);
        checkOutput("clr_alone_b", 32'(bus.err_cnt_o), 32'd0);
        checkOutput("pre_reset_lock", 32'(bus.lock_o), 32'd1);

        $display("[TB] reset mid-lock");
        @(negedge clk_i);
        bus.rx_valid_i = 1'b0;
        rst_n_i        = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 1; i <= LOCK_CNT + 1; i++) begin
            send_clean(1, 1'b0);
            if (i == LOCK_CNT) checkOutput("rst_lock_word16", 32'(bus.lock_o), 32'd0);
            if (i == LOCK_CNT + 1) checkOutput("rst_lock_word17", 32'(bus.lock_o), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
